// File: rtl/env_vca_pkg.sv
// ============================================================================
//  Module   : env_vca_pkg
//  Purpose  : Shared synth constants (audio sample width, envelope width and
//             default VCA gain slew) used by the envelope generator, the
//             oscillators and the VCA.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package env_vca_pkg;

    // Signed audio sample width shared by oscillators and the VCA.
    localparam int SYNTH_SAMPLE_WIDTH = 16;

    // Envelope width; equals the envelope generator's ACCUMULATOR_BITS.
    localparam int SYNTH_ENV_WIDTH    = 16;

    // Default maximum gain change per accepted sample.
    localparam int SYNTH_SLEW_STEP    = 256;

endpackage : env_vca_pkg

`default_nettype wire

// File: rtl/vca_slew.sv
// ============================================================================
//  Module   : vca_slew
//  Purpose  : Slew-rate limiter for the VCA gain. On each enable the level
//             jumps to the target if it is within SLEW_STEP, otherwise it
//             moves toward the target by exactly SLEW_STEP.
//  Ports    : clk    - clock, rising edge
//             rst    - asynchronous active-high reset (level -> 0)
//             en     - update strobe (one per accepted sample)
//             target - requested level (unsigned)
//             level  - current smoothed level (unsigned)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vca_slew
    import env_vca_pkg::*;
#(
    parameter int ENV_WIDTH = SYNTH_ENV_WIDTH,
    parameter int SLEW_STEP = SYNTH_SLEW_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ENV_WIDTH-1:0] target,
    output logic [ENV_WIDTH-1:0] level
);

    // One extra bit so distances and the step compare without wrap.
    localparam logic [ENV_WIDTH:0] c_STEP = (ENV_WIDTH + 1)'(SLEW_STEP);

    logic [ENV_WIDTH-1:0] r_level;
    logic [ENV_WIDTH-1:0] w_next;
    logic [ENV_WIDTH:0]   w_dist_up;
    logic [ENV_WIDTH:0]   w_dist_dn;
    logic                 w_rising;

    assign w_rising  = (target >= r_level);
    assign w_dist_up = {1'b0, target}  - {1'b0, r_level};
    assign w_dist_dn = {1'b0, r_level} - {1'b0, target};

    // The step branches are only taken when the distance exceeds the step,
    // so neither the add nor the subtract can wrap.
    always_comb begin
        w_next = r_level;
        if (w_rising) begin
            if (w_dist_up <= c_STEP) begin
                w_next = target;
            end else begin
                w_next = r_level + c_STEP[ENV_WIDTH-1:0];
            end
        end else begin
            if (w_dist_dn <= c_STEP) begin
                w_next = target;
            end else begin
                w_next = r_level - c_STEP[ENV_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (en) begin
            r_level <= w_next;
        end
    end

    assign level = r_level;

endmodule : vca_slew

`default_nettype wire

// File: rtl/env_vca.sv
// ============================================================================
//  Module   : env_vca
//  Purpose  : Voltage-controlled amplifier. Scales a signed sample stream by
//             a slew-limited unsigned envelope gain through a 3-stage
//             valid/ready pipeline (capture -> product -> output).
//  Ports    : clk      - clock, rising edge
//             rst      - asynchronous active-high reset
//             env_in   - envelope level, sampled only on an accept
//             s_valid  / s_ready / s_data  - input sample stream
//             m_valid  / m_ready / m_data  - output sample stream
//             gain     - current smoothed gain register
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module env_vca
    import env_vca_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SYNTH_SAMPLE_WIDTH,
    parameter int ENV_WIDTH    = SYNTH_ENV_WIDTH,
    parameter int SLEW_STEP    = SYNTH_SLEW_STEP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ENV_WIDTH-1:0]    env_in,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [SAMPLE_WIDTH-1:0] m_data,
    output logic [ENV_WIDTH-1:0]    gain
);

    localparam int c_PROD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;

    logic                       w_adv;
    logic                       w_accept;
    logic [ENV_WIDTH-1:0]       w_gain;

    // P1: sample plus the gain in force before this accept's update
    logic                       r_v1;
    logic [SAMPLE_WIDTH-1:0]    r_s1;
    logic [ENV_WIDTH-1:0]       r_g1;

    // P2: full-precision product
    logic                       r_v2;
    logic signed [c_PROD_W-1:0] r_p2;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_shifted;

    // P3: output register
    logic                       r_v3;
    logic [SAMPLE_WIDTH-1:0]    r_d3;

    logic                       w_unused_hi;

    // Whole pipeline moves in lockstep whenever the output slot is free.
    assign w_adv    = m_ready | ~r_v3;
    assign w_accept = s_valid & w_adv;

    vca_slew #(
        .ENV_WIDTH (ENV_WIDTH),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk    (clk),
        .rst    (rst),
        .en     (w_accept),
        .target (env_in),
        .level  (w_gain)
    );

    // Gain is zero-extended so it multiplies as a non-negative value.
    assign w_prod    = $signed(r_s1) * $signed({1'b0, r_g1});
    // Arithmetic shift floors toward minus infinity; max |gain| < 2^ENV_WIDTH
    // keeps the result inside SAMPLE_WIDTH bits.
    assign w_shifted = r_p2 >>> ENV_WIDTH;
    assign w_unused_hi = ^w_shifted[c_PROD_W-1:SAMPLE_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
            r_g1 <= '0;
            r_v2 <= 1'b0;
            r_p2 <= '0;
            r_v3 <= 1'b0;
            r_d3 <= '0;
        end else if (w_adv) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (w_accept) begin
                r_s1 <= s_data;
                r_g1 <= w_gain;
            end
            if (r_v1) begin
                r_p2 <= w_prod;
            end
            if (r_v2) begin
                r_d3 <= w_shifted[SAMPLE_WIDTH-1:0];
            end
        end
    end

    assign s_ready = w_adv;
    assign m_valid = r_v3;
    assign m_data  = r_d3;
    assign gain    = w_gain;

endmodule : env_vca

`default_nettype wire

// File: doc/env_vca.md
ENV_VCA -- requirements
Module: env_vca

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, meaning the signed audio sample width.
REQ-002 SHALL have parameter ENV_WIDTH, default 16, meaning the unsigned envelope width, matching the envelope generator's ACCUMULATOR_BITS.
REQ-003 SHALL have parameter SLEW_STEP, default 256, meaning the maximum gain change per accepted sample.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port env_in, input, ENV_WIDTH bits: unsigned envelope level driven by the envelope generator's signal_out.
REQ-007 SHALL have port s_valid, input, 1 bit: an input sample is present.
REQ-008 SHALL have port s_ready, output, 1 bit: the block can accept an input sample.
REQ-009 SHALL have port s_data, input, SAMPLE_WIDTH bits: signed oscillator sample.
REQ-010 SHALL have port m_valid, output, 1 bit: an output sample is present.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts the output sample.
REQ-012 SHALL have port m_data, output, SAMPLE_WIDTH bits: signed scaled sample.
REQ-013 SHALL have port gain, output, ENV_WIDTH bits: current smoothed gain register value.

Function
REQ-014 SHALL form a 3-register pipeline (P1: sample and gain capture; P2: product; P3: output), advancing only when adv = m_ready OR NOT m_valid.
REQ-015 SHALL drive s_ready = adv combinationally, giving a throughput of 1 sample/cycle with no bubbles while m_ready is held high.
REQ-016 SHALL treat an accept as s_valid AND s_ready; an accepted sample SHALL appear on m_data with m_valid high exactly 3 cycles after the accept edge if m_ready has stayed high.
REQ-017 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0, and SHALL neither drop nor duplicate samples under any backpressure pattern.
REQ-018 SHALL propagate valid bits per stage; bubbles (no accept while adv=1) SHALL travel as invalid stages.
REQ-019 SHALL update gain only on an accept, as follows:
- if |env_in - gain| <= SLEW_STEP: gain := env_in;
- else: gain moves toward env_in by exactly SLEW_STEP.
REQ-020 SHALL capture the gain value before the REQ-019 update into P1 alongside the sample.
REQ-021 SHALL compute product = signed(s_data) x unsigned(gain) at full precision (SAMPLE_WIDTH+ENV_WIDTH+1 bits) and output product arithmetically shifted right by ENV_WIDTH (floor).
REQ-022 SHALL never overflow, since gain <= 2^ENV_WIDTH-1; no saturation logic is required.
REQ-023 SHALL treat env_in as sampled at the accept edge only; env_in changes between accepts have no effect.

Reset
REQ-024 SHALL, on rst high at any time: m_valid=0, m_data=0, all stage valids=0, gain=0; all pipeline contents are discarded immediately, without waiting for a clock edge.
REQ-025 SHALL assert s_ready=1 in the first cycle after rst is released.

Structure
REQ-026 SHALL place the SAMPLE_WIDTH and ENV_WIDTH defaults in the shared synth constants package used by the envelope generator and the oscillators.
REQ-027 SHALL implement the slew limiter (REQ-019) as sub-module vca_slew (clk, rst, en, target, level).

Verification
REQ-028 Reset, then env_in=65535 held, 300 accepts -> gain reads 256, 512, ..., 65280, then 65535 from accept 256 onward.
REQ-029 gain=65535, s_data=32767 -> m_data=32766; s_data=-32768 -> m_data=-32768; s_data=-1 with gain=0 -> m_data=0.
REQ-030 s_valid continuously high and m_ready=1, samples 1..10 -> outputs in order, first at cycle 3 after the first accept, one per cycle.
REQ-031 m_ready toggled pseudo-randomly for 1000 samples -> scoreboard shows no loss, no duplicates, and m_data stable while stalled.
REQ-032 gain=1000, env_in=900 -> gain becomes 900 in one accept; env_in=0 from gain=1000 -> gain reads 744, 488, 232, 0.
REQ-033 rst asserted mid-stream with 3 samples in flight -> m_valid=0 immediately; after release, no stale sample is emitted and gain=0.
